cont_mod_n: RTL and testbench

- Parametrised multi-digit modulo counter; successor to the single-digit 0..5 counter.
- N_DIG digits of WIDTH bits each; each digit has its own terminal value. Default is a 00..59 minute/second counter.
- Supports up/down counting, parallel load with per-digit clamping, terminal count and cascade enable.
- Used in timekeeping and display chains. CEO drives Enable of the next counter stage.

---
 rtl/cont_mod_n.sv | 79 +++++++
 tb/tb_cont_mod_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cont_mod_n.sv
// cont_mod_n: N_DIG-digit up/down modulo counter, per-digit max and load clamp.
// Define CONT_SAT_EN to hold at terminal count instead of wrapping.
module cont_mod_n #(
  parameter int unsigned N_DIG = 2,
  parameter int unsigned WIDTH = 4,
  parameter logic [N_DIG*WIDTH-1:0] MAX_VEC = 8'h59
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Load,
  input  logic                   Enable,
  input  logic                   Dir,
  input  logic [N_DIG*WIDTH-1:0] Valor,
  output logic [N_DIG*WIDTH-1:0] Cuenta,
  output logic [N_DIG-1:0]       DigTC,
  output logic                   TCO,
  output logic                   CEO
);

  logic [N_DIG*WIDTH-1:0] r_cnt;
  logic [N_DIG*WIDTH-1:0] w_ld;
  logic [N_DIG*WIDTH-1:0] w_step;
  logic [N_DIG-1:0]       w_carry;
  logic [N_DIG-1:0]       w_en;
  logic                   w_run;

  assign Cuenta = r_cnt;
  assign TCO    = &DigTC;
  assign CEO    = TCO & Enable;

`ifdef CONT_SAT_EN
  assign w_run = Enable & ~TCO;
`else
  assign w_run = Enable;
`endif

  // Ripple carry: a digit steps only when all lower digits are terminal.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int i = 1; i < N_DIG; i++)
      w_carry[i] = w_carry[i-1] & DigTC[i-1];
  end

  assign w_en = w_carry & {N_DIG{w_run}};

  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_val;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;

    assign w_max = MAX_VEC[g*WIDTH +: WIDTH];
    assign w_cur = r_cnt[g*WIDTH +: WIDTH];
    assign w_val = Valor[g*WIDTH +: WIDTH];

    assign DigTC[g] = Dir ? (w_cur == w_max) : (w_cur == '0);

    // Above-max states wrap to 0 going up, decrement going down.
    assign w_up = (w_cur >= w_max) ? '0 : w_cur + WIDTH'(1);
    assign w_dn = (w_cur == '0) ? w_max : w_cur - WIDTH'(1);

    assign w_ld[g*WIDTH +: WIDTH] = (w_val > w_max) ? w_max : w_val;

    assign w_step[g*WIDTH +: WIDTH] =
      !w_en[g] ? w_cur : (Dir ? w_up : w_dn);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n)
      r_cnt <= '0;
    else if (Load)
      r_cnt <= w_ld;
    else
      r_cnt <= w_step;
  end

endmodule

// File: tb/tb_cont_mod_n.sv
// tb_cont_mod_n: directed checks of the default 00..59 counter build.
// Covers reset, up/down wrap, load clamp, priority, hold and Dir flip.
module tb_cont_mod_n;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Load;
  logic       Enable;
  logic       Dir;
  logic [7:0] Valor;
  logic [7:0] Cuenta;
  logic [1:0] DigTC;
  logic       TCO;
  logic       CEO;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  cont_mod_n #(
    .N_DIG(2),
    .WIDTH(4),
    .MAX_VEC(8'h59)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Load(Load),
    .Enable(Enable),
    .Dir(Dir),
    .Valor(Valor),
    .Cuenta(Cuenta),
    .DigTC(DigTC),
    .TCO(TCO),
    .CEO(CEO)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic load(input logic [7:0] v);
    Load  = 1'b1;
    Valor = v;
    step();
    Load  = 1'b0;
  endtask

  initial begin
    int v;
    Rst_n  = 1'b0;
    Load   = 1'b0;
    Enable = 1'b0;
    Dir    = 1'b1;
    Valor  = 8'h00;
    step();
    step();
    chk("rst_cnt", Cuenta, 8'h00);
    chk("rst_tco_up", TCO, 1'b0);
    chk("rst_ceo_up", CEO, 1'b0);
    Dir = 1'b0;
    #1;
    chk("rst_digtc_dn", DigTC, 2'b11);
    chk("rst_tco_dn", TCO, 1'b1);
    chk("rst_ceo_dn_en0", CEO, 1'b0);
    Enable = 1'b1;
    #1;
    chk("rst_ceo_dn_en1", CEO, 1'b1);

    Dir   = 1'b1;
    Rst_n = 1'b1;
    #1;
    for (int i = 0; i <= 60; i++) begin
      v = i % 60;
      chk($sformatf("up_cnt_%0d", i), Cuenta, bcd(v));
      chk($sformatf("up_tco_%0d", i), TCO, v == 59);
      chk($sformatf("up_ceo_%0d", i), CEO, v == 59);
      step();
    end
    chk("up_after_wrap", Cuenta, 8'h01);

    load(8'h10);
    chk("ld_10", Cuenta, 8'h10);
    Dir = 1'b0;
    #1;
    chk("dn_digtc_10", DigTC, 2'b01);
    chk("dn_tco_10", TCO, 1'b0);
    for (int j = 0; j < 12; j++) begin
      v = (70 - j) % 60;
      chk($sformatf("dn_cnt_%0d", j), Cuenta, bcd(v));
      chk($sformatf("dn_tco_%0d", j), TCO, v == 0);
      step();
    end
    chk("dn_after_wrap", Cuenta, 8'h58);

    Enable = 1'b0;
    Dir    = 1'b1;
    load(8'h7C);
    chk("clamp_7c", Cuenta, 8'h59);
    load(8'h3A);
    chk("clamp_3a", Cuenta, 8'h39);
    load(8'hF5);
    chk("clamp_f5", Cuenta, 8'h55);
    Enable = 1'b1;
    load(8'h21);
    chk("ld_over_en", Cuenta, 8'h21);

    Enable = 1'b0;
    load(8'h47);
    chk("ld_47", Cuenta, 8'h47);
    Rst_n = 1'b0;
    load(8'h33);
    chk("rst_over_ld", Cuenta, 8'h00);
    Rst_n = 1'b1;

    load(8'h47);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hold_%0d", k), Cuenta, 8'h47);
    end

    load(8'h59);
    #1;
    chk("flip_tco_up", TCO, 1'b1);
    chk("flip_ceo_en0", CEO, 1'b0);
    Enable = 1'b1;
    #1;
    chk("flip_ceo_en1", CEO, 1'b1);
    Dir = 1'b0;
    #1;
    chk("flip_tco_dn", TCO, 1'b0);
    chk("flip_digtc_dn", DigTC, 2'b00);
    chk("flip_ceo_dn", CEO, 1'b0);
    step();
    chk("flip_next", Cuenta, 8'h58);

    Dir = 1'b1;
    load(8'h29);
    step();
    chk("carry_29", Cuenta, 8'h30);
    Dir = 1'b0;
    step();
    chk("borrow_30", Cuenta, 8'h29);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
